// File: rtl/fifo_ptr_ctrl.sv
// Pointer/flag controller that turns a dual-pointer memory into a FIFO.
// Optional FIFO_USAGE_EN adds a registered occupancy output port.
`timescale 1ns/1ps
module fifo_ptr_ctrl #(
  parameter int unsigned MAIN_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clr_err,
  input  logic [MAIN_SIZE:0]   afull_thr,
  input  logic [MAIN_SIZE:0]   aempty_thr,
  output logic                 write,
  output logic                 read,
  output logic [MAIN_SIZE-1:0] wr_ptr,
  output logic [MAIN_SIZE-1:0] rd_ptr,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 err_overflow,
  output logic                 err_underflow
`ifdef FIFO_USAGE_EN
  ,
  output logic [MAIN_SIZE:0]   usage
`endif
);

  localparam int unsigned PW    = MAIN_SIZE;
  localparam int unsigned CW    = MAIN_SIZE + 1;
  localparam int unsigned DEPTH = 2 ** MAIN_SIZE;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err_ovf;
  logic          r_err_unf;

  logic          w_full;
  logic          w_empty;
  logic          w_write;
  logic          w_read;
  logic          w_ovf_set;
  logic          w_unf_set;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_err_ovf_nxt;
  logic          w_err_unf_nxt;

  // Occupancy flags come straight from the registered count
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == CW'(0));

  // Strobes are gated by reset so an in-flight push is never committed
  assign w_write   = reset & push & (~w_full | pop);
  assign w_read    = reset & pop & ~w_empty;
  assign w_ovf_set = reset & push & w_full & ~pop;
  assign w_unf_set = reset & pop & w_empty;

  always_comb begin
    w_wr_ptr_nxt  = r_wr_ptr;
    w_rd_ptr_nxt  = r_rd_ptr;
    w_count_nxt   = r_count;
    w_err_ovf_nxt = r_err_ovf & ~clr_err;
    w_err_unf_nxt = r_err_unf & ~clr_err;
    if (w_write) begin
      w_wr_ptr_nxt = r_wr_ptr + PW'(1);
    end
    if (w_read) begin
      w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    end
    case ({w_write, w_read})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
    // A fresh error in the clearing cycle takes priority over the clear
    if (w_ovf_set) begin
      w_err_ovf_nxt = 1'b1;
    end
    if (w_unf_set) begin
      w_err_unf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_count   <= w_count_nxt;
      r_err_ovf <= w_err_ovf_nxt;
      r_err_unf <= w_err_unf_nxt;
    end
  end

  assign write         = w_write;
  assign read          = w_read;
  assign wr_ptr        = r_wr_ptr;
  assign rd_ptr        = r_rd_ptr;
  assign full          = w_full;
  assign empty         = w_empty;
  // Thresholds above DEPTH leave almost_full permanently low
  assign almost_full   = (r_count >= afull_thr);
  assign almost_empty  = (r_count <= aempty_thr);
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;

`ifdef FIFO_USAGE_EN
  assign usage = r_count;
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Scoreboard bench for fifo_ptr_ctrl (MAIN_SIZE=3, DEPTH=8, afull=6, aempty=1).
// A bench-side memory holds written data so read order can be verified.
`timescale 1ns/1ps
module tb_fifo_ptr_ctrl;

  localparam int unsigned MS = 3;

  logic          clk;
  logic          reset;
  logic          push;
  logic          pop;
  logic          clr_err;
  logic [MS:0]   afull_thr;
  logic [MS:0]   aempty_thr;
  logic          write;
  logic          read;
  logic [MS-1:0] wr_ptr;
  logic [MS-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          err_overflow;
  logic          err_underflow;
`ifdef FIFO_USAGE_EN
  logic [MS:0]   usage;
`endif

  fifo_ptr_ctrl #(.MAIN_SIZE(MS)) dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .pop           (pop),
    .clr_err       (clr_err),
    .afull_thr     (afull_thr),
    .aempty_thr    (aempty_thr),
    .write         (write),
    .read          (read),
    .wr_ptr        (wr_ptr),
    .rd_ptr        (rd_ptr),
    .full          (full),
    .empty         (empty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
`ifdef FIFO_USAGE_EN
    ,
    .usage         (usage)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: write read wr_ptr rd_ptr full empty afull aempty ovf unf
  logic [13:0] exp_q[$];
  string       name_q[$];
  logic [7:0]  rd_q[$];
  logic        vec_valid;
  logic [7:0]  exp_data;
  int          checks;
  int          errors;

  // Memory the controller drives: sync write, combinational read
  logic [7:0] mem [8];
  logic [7:0] wdata;
  always @(posedge clk) begin
    if (write === 1'b1) begin
      mem[wr_ptr] <= wdata;
      wdata       <= wdata + 8'd1;
    end
  end

  always @(negedge clk) begin
    if (vec_valid && exp_q.size() > 0) begin
      logic [13:0] e;
      logic [13:0] g;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      g  = {write, read, wr_ptr, rd_ptr, full, empty, almost_full, almost_empty,
            err_overflow, err_underflow};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s: got w=%b r=%b wp=%0d rp=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b, required w=%b r=%b wp=%0d rp=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b",
                 nm, g[13], g[12], g[11:9], g[8:6], g[5], g[4], g[3], g[2], g[1], g[0],
                 e[13], e[12], e[11:9], e[8:6], e[5], e[4], e[3], e[2], e[1], e[0]);
      end
      if (read === 1'b1) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL %s rdata: read strobe with no entry expected, got %0d", nm, mem[rd_ptr]);
        end else begin
          logic [7:0] d;
          d = rd_q.pop_front();
          if (mem[rd_ptr] !== d) begin
            errors++;
            $display("FAIL %s rdata: got %0d required %0d", nm, mem[rd_ptr], d);
          end
        end
      end
    end
  end

  task automatic step(input string nm, input logic p, input logic q, input logic c,
                      input logic rst, input logic ew, input logic er, input int ewp,
                      input int erp, input logic ef, input logic ee, input logic eaf,
                      input logic eae, input logic eov, input logic eun);
    @(posedge clk);
    #1;
    push    = p;
    pop     = q;
    clr_err = c;
    reset   = ~rst;
    if (rst) rd_q.delete();
    exp_q.push_back({ew, er, 3'(ewp), 3'(erp), ef, ee, eaf, eae, eov, eun});
    name_q.push_back(nm);
    if (ew) begin
      rd_q.push_back(exp_data);
      exp_data = exp_data + 8'd1;
    end
    vec_valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    clr_err    = 1'b0;
    afull_thr  = 4'd6;
    aempty_thr = 4'd1;
    vec_valid  = 1'b0;
    exp_data   = 8'd0;
    wdata      = 8'd0;
    checks     = 0;
    errors     = 0;
    repeat (3) @(posedge clk);

    step("reset_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++)
      step("fill", 1, 0, 0, 0, 1, 0, i, 0, 0, i == 0, i >= 6, i <= 1, 0, 0);
    step("push_at_full", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      step("drain", 0, 1, 0, 0, 0, 1, 0, i, i == 0, 0, (8 - i) >= 6, (8 - i) <= 1, 1, 0);
    step("pop_at_empty", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
    step("clr_err", 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1);
    step("both_at_empty", 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++)
      step("refill", 1, 0, 0, 0, 1, 0, 1 + i, 0, 0, 0, (1 + i) >= 6, (1 + i) <= 1, 0, 1);
    step("both_at_full", 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 1);
    step("clr_with_new_err", 1, 0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      step("pop_to_4", 0, 1, 0, 0, 0, 1, 1, 1 + i, i == 0, 0, (8 - i) >= 6, 0, 1, 0);
    step("clr_at_4", 0, 0, 1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 20; k++)
      step("wrap_stress", 1, 1, 0, 0, 1, 1, (1 + k) % 8, (5 + k) % 8, 0, 0, 0, 0, 0, 0);
    step("reset_mid_push", 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step("after_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step("push_after_reset", 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    step("pop_after_reset", 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    step("final_idle", 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (rd_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queues: got rd_q=%0d exp_q=%0d pending, required 0", rd_q.size(), exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
